lifo_stack: RTL

LIFO_STACK -- requirements
Module: lifo_stack

---
 rtl/stack_pkg.sv | 21 ++
 rtl/stack_regfile.sv | 24 ++
 rtl/lifo_stack.sv | 102 ++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared constants and request decode for the LIFO stack block.
package stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 8;
  localparam int STACK_PTR_W = 3;
  localparam int STACK_CNT_W = 4;

  // Raw request seen on one clock edge, before full/empty qualification
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_SWAP = 2'b11
  } stack_op_e;

  function automatic stack_op_e stack_op(input logic push, input logic pop);
    return stack_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH storage: one synchronous write port, one combinational read port.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are not reset; a slot is only ever read after it was written
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack: count register, push/pop decode and registered pop output.
module lifo_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  stack_op_e        op;
  logic             do_pop;
  logic             do_push;
  logic [CNT_W-1:0] top_idx;
  logic [PTR_W-1:0] waddr;
  logic [WIDTH-1:0] rdata;

  // Flags decode straight from the registered count
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  assign top_idx = count - CNT_W'(1);

  // Qualify the raw request; a swap on a full stack frees the top slot first
  always_comb begin
    op      = stack_op(push, pop);
    do_pop  = 1'b0;
    do_push = 1'b0;
    waddr   = count[PTR_W-1:0];
    unique case (op)
      OP_PUSH: do_push = !full;
      OP_POP:  do_pop  = !empty;
      OP_SWAP: begin
        do_pop  = !empty;
        do_push = 1'b1;
        // Swap overwrites the slot being popped; on empty it writes slot 0
        if (!empty) waddr = top_idx[PTR_W-1:0];
      end
      default: ;
    endcase
  end

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_regfile (
    .clk   (clk),
    .we    (do_push),
    .waddr (waddr),
    .wdata (din),
    .raddr (top_idx[PTR_W-1:0]),
    .rdata (rdata)
  );

  // Count moves only when exactly one of push/pop is accepted
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      count <= '0;
    end else if (do_push && !do_pop) begin
      count <= count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count <= count - CNT_W'(1);
    end
  end

  // Popped word is registered and held until the next accepted pop
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= do_pop;
      if (do_pop) dout <= rdata;
    end
  end

  // Rejection pulses: push blocked by full, pop blocked by empty
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (op == OP_PUSH) && full;
      underflow <= pop && empty;
    end
  end

endmodule
